// File: rtl/dcache_store_buffer_if.sv
// Bus bundle between the MEM-stage store commit / load path and the store
// buffer, plus the buffer's single drain port toward the data cache.
//   master : pipeline + cache side (drives st_*, ld_*, cache_ack)
//   slave  : store buffer (drives st_ready, ld_stall/ld_grant, cache_*, buf_*)
interface dcache_store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic             st_valid;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [3:0]       st_wen;
    logic             st_ready;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic             ld_stall;
    logic             ld_grant;
    logic             cache_req;
    logic [31:0]      cache_addr;
    logic [31:0]      cache_wdata;
    logic [3:0]       cache_wen;
    logic             cache_ack;
    logic             buf_empty;
    logic [CNT_W-1:0] buf_count;

    modport master (
        output st_valid, st_addr, st_data, st_wen, ld_valid, ld_addr, cache_ack,
        input  st_ready, ld_stall, ld_grant, cache_req, cache_addr, cache_wdata,
               cache_wen, buf_empty, buf_count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_wen, ld_valid, ld_addr, cache_ack,
        output st_ready, ld_stall, ld_grant, cache_req, cache_addr, cache_wdata,
               cache_wen, buf_empty, buf_count
    );
endinterface

// File: rtl/dcache_store_buffer.sv
// Store buffer: small FIFO of committed stores in front of the single
// data-cache port. Loads get the port while the buffer is not full; the
// buffer drains one entry per request when the port is otherwise idle,
// and flags loads that hit a buffered word so they stall.
// Ports:
//   clk, resetn : core clock, asynchronous active-low reset
//   sb (slave)  : store push, load arbitration/hazard, cache drain, status
module dcache_store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    dcache_store_buffer_if.slave  sb
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                   state;
    logic [DEPTH-1:0]         entValid;
    logic [DEPTH-1:0][29:0]   entAddr;
    logic [DEPTH-1:0][31:0]   entData;
    logic [DEPTH-1:0][3:0]    entWen;
    logic [PTR_W-1:0]         head, tail;
    logic [CNT_W-1:0]         count, countNext;
    logic                     emptyQ;

    logic                     reqQ;
    logic [29:0]              reqAddrQ;
    logic [31:0]              reqDataQ;
    logic [3:0]               reqWenQ;

    logic                     full, push, pop, bufHit, pushHit, ldStall;
    logic [DEPTH-1:0]         hitVec;
    logic                     unusedAddrBits;

    assign full    = (count == CNT_W'(DEPTH));
    // A zero byte-enable store is consumed without taking an entry.
    assign push    = sb.st_valid && !full && (sb.st_wen != 4'b0000);
    assign pop     = (state == REQ) && sb.cache_ack;

    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        // Head under drain stays valid until its ack, so it keeps matching.
        assign hitVec[i] = entValid[i] && (entAddr[i] == sb.ld_addr[31:2]);
    end

    assign bufHit  = |hitVec;
    assign pushHit = push && (sb.st_addr[31:2] == sb.ld_addr[31:2]);
    assign ldStall = sb.ld_valid && (bufHit || pushHit);

    assign countNext = count + CNT_W'(push) - CNT_W'(pop);

    assign sb.st_ready    = !full;
    assign sb.ld_stall    = ldStall;
    assign sb.ld_grant    = (state == IDLE) && sb.ld_valid && !ldStall && !full;
    assign sb.cache_req   = reqQ;
    assign sb.cache_addr  = {reqAddrQ, 2'b00};
    assign sb.cache_wdata = reqDataQ;
    assign sb.cache_wen   = reqWenQ;
    assign sb.buf_empty   = emptyQ;
    assign sb.buf_count   = count;

    assign unusedAddrBits = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

    // Entry payload carries no reset; validity alone defines occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            entAddr[tail] <= sb.st_addr[31:2];
            entData[tail] <= sb.st_data;
            entWen[tail]  <= sb.st_wen;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entValid <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            emptyQ   <= 1'b1;
        end else begin
            // push and pop never target the same slot: a push into the
            // head slot needs a full buffer, which refuses the push.
            if (push) begin
                entValid[tail] <= 1'b1;
                tail           <= tail + PTR_W'(1);
            end
            if (pop) begin
                entValid[head] <= 1'b0;
                head           <= head + PTR_W'(1);
            end
            count  <= countNext;
            emptyQ <= (countNext == '0);
        end
    end

    // Drain FSM; cache_* are registered and held until ack, never retracted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            reqQ     <= 1'b0;
            reqAddrQ <= '0;
            reqDataQ <= '0;
            reqWenQ  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((count != '0) && (!sb.ld_valid || full || ldStall)) begin
                        state    <= REQ;
                        reqQ     <= 1'b1;
                        reqAddrQ <= entAddr[head];
                        reqDataQ <= entData[head];
                        reqWenQ  <= entWen[head];
                    end
                end
                REQ: begin
                    // Returning to IDLE for a cycle leaves a load slot
                    // between back-to-back drains.
                    if (sb.cache_ack) begin
                        state    <= IDLE;
                        reqQ     <= 1'b0;
                        reqAddrQ <= '0;
                        reqDataQ <= '0;
                        reqWenQ  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_store_buffer.sv
module tb_dcache_store_buffer;
    logic clk;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    logic allowDrop = 1'b0;

    dcache_store_buffer_if #(.DEPTH(4)) sbIf ();

    dcache_store_buffer #(.DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sb     (sbIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A store offered while the buffer is full is a pipeline bug unless a
    // scenario does it on purpose.
    always @(posedge clk) begin
        if (resetn && sbIf.st_valid && !sbIf.st_ready && !allowDrop) begin
            errors++;
            $display("FAIL protocol st_valid while st_ready=0 at %0t", $time);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushStore(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        sbIf.st_valid = 1'b1;
        sbIf.st_addr  = a;
        sbIf.st_data  = d;
        sbIf.st_wen   = w;
    endtask

    // Acks every request until the buffer is empty or the budget expires.
    task automatic drainAll(input int maxCycles, output int drained);
        int cyc = 0;
        drained = 0;
        while (!(sbIf.buf_empty && !sbIf.cache_req) && cyc < maxCycles) begin
            if (sbIf.cache_req) begin
                sbIf.cache_ack = 1'b1;
                tick();
                sbIf.cache_ack = 1'b0;
                drained++;
            end else begin
                tick();
            end
            cyc++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        sbIf.st_valid = 0; sbIf.st_addr = 0; sbIf.st_data = 0; sbIf.st_wen = 0;
        sbIf.ld_valid = 0; sbIf.ld_addr = 0; sbIf.cache_ack = 0;
        repeat (2) tick();
        checks++; if (sbIf.cache_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", sbIf.cache_req); end
        checks++; if (sbIf.cache_addr !== 32'h0 || sbIf.cache_wdata !== 32'h0 || sbIf.cache_wen !== 4'h0) begin
            errors++; $display("FAIL reset_bus got %h/%h/%h exp 0", sbIf.cache_addr, sbIf.cache_wdata, sbIf.cache_wen); end
        checks++; if (sbIf.buf_empty !== 1'b1 || sbIf.buf_count !== 3'd0 || sbIf.st_ready !== 1'b1) begin
            errors++; $display("FAIL reset_status got empty=%b count=%0d ready=%b exp 1/0/1", sbIf.buf_empty, sbIf.buf_count, sbIf.st_ready); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_push();
        pushStore(32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
        tick();
        sbIf.st_valid = 0;
        #1;
        checks++; if (sbIf.buf_count !== 3'd1 || sbIf.buf_empty !== 1'b0 || sbIf.cache_req !== 1'b0) begin
            errors++; $display("FAIL single_after_push got count=%0d empty=%b req=%b exp 1/0/0", sbIf.buf_count, sbIf.buf_empty, sbIf.cache_req); end
        tick();
        checks++; if (sbIf.cache_req !== 1'b1) begin errors++; $display("FAIL single_req_latency got %b exp 1", sbIf.cache_req); end
        checks++; if (sbIf.cache_addr !== 32'h1000_0004 || sbIf.cache_wdata !== 32'hDEAD_BEEF || sbIf.cache_wen !== 4'hF) begin
            errors++; $display("FAIL single_bus got %h/%h/%h exp 10000004/deadbeef/f", sbIf.cache_addr, sbIf.cache_wdata, sbIf.cache_wen); end
        tick();
        sbIf.cache_ack = 1'b1;
        tick();
        sbIf.cache_ack = 1'b0;
        #1;
        checks++; if (sbIf.buf_empty !== 1'b1 || sbIf.buf_count !== 3'd0 || sbIf.cache_req !== 1'b0) begin
            errors++; $display("FAIL single_after_ack got empty=%b count=%0d req=%b exp 1/0/0", sbIf.buf_empty, sbIf.buf_count, sbIf.cache_req); end
        tick();
    endtask

    task automatic test_fill_and_order();
        logic [31:0] expAddr;
        int n;
        for (int i = 0; i < 4; i++) begin
            pushStore(32'h0000_0100 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF);
            tick();
        end
        sbIf.st_valid = 0;
        #1;
        checks++; if (sbIf.buf_count !== 3'd4 || sbIf.st_ready !== 1'b0) begin
            errors++; $display("FAIL fill_full got count=%0d ready=%b exp 4/0", sbIf.buf_count, sbIf.st_ready); end
        allowDrop = 1'b1;
        pushStore(32'h0000_0110, 32'hBAD0_0005, 4'hF);
        tick();
        sbIf.st_valid = 0;
        allowDrop = 1'b0;
        #1;
        checks++; if (sbIf.buf_count !== 3'd4) begin errors++; $display("FAIL fill_fifth_refused got count=%0d exp 4", sbIf.buf_count); end
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!sbIf.cache_req && n < 8) begin tick(); n++; end
            expAddr = 32'h0000_0100 + 32'(i * 4);
            checks++; if (sbIf.cache_req !== 1'b1) begin errors++; $display("FAIL fill_drain_timeout entry %0d got req=%b exp 1", i, sbIf.cache_req); end
            checks++; if (sbIf.cache_addr !== expAddr || sbIf.cache_wdata !== 32'hA0 + 32'(i)) begin
                errors++; $display("FAIL fill_order entry %0d got %h/%h exp %h/%h", i, sbIf.cache_addr, sbIf.cache_wdata, expAddr, 32'hA0 + 32'(i)); end
            sbIf.cache_ack = 1'b1;
            tick();
            sbIf.cache_ack = 1'b0;
        end
        #1;
        checks++; if (sbIf.buf_empty !== 1'b1) begin errors++; $display("FAIL fill_empty got %b exp 1", sbIf.buf_empty); end
        repeat (3) tick();
        checks++; if (sbIf.cache_req !== 1'b0) begin errors++; $display("FAIL fill_no_extra got req=%b exp 0", sbIf.cache_req); end
    endtask

    task automatic test_load_priority();
        int drained;
        sbIf.ld_valid = 1'b1;
        sbIf.ld_addr  = 32'h3000_0000;
        pushStore(32'h0000_0200, 32'h1, 4'hF);
        tick();
        pushStore(32'h0000_0204, 32'h2, 4'hF);
        tick();
        sbIf.st_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (sbIf.buf_count !== 3'd2 || sbIf.ld_grant !== 1'b1 || sbIf.cache_req !== 1'b0) begin
                errors++; $display("FAIL prio_load_wins got count=%0d grant=%b req=%b exp 2/1/0", sbIf.buf_count, sbIf.ld_grant, sbIf.cache_req); end
            tick();
        end
        pushStore(32'h0000_0208, 32'h3, 4'hF);
        tick();
        pushStore(32'h0000_020C, 32'h4, 4'hF);
        tick();
        sbIf.st_valid = 0;
        #1;
        checks++; if (sbIf.buf_count !== 3'd4 || sbIf.ld_grant !== 1'b0) begin
            errors++; $display("FAIL prio_full_grant got count=%0d grant=%b exp 4/0", sbIf.buf_count, sbIf.ld_grant); end
        tick();
        checks++; if (sbIf.cache_req !== 1'b1 || sbIf.cache_addr !== 32'h0000_0200 || sbIf.ld_grant !== 1'b0) begin
            errors++; $display("FAIL prio_full_drain got req=%b addr=%h grant=%b exp 1/00000200/0", sbIf.cache_req, sbIf.cache_addr, sbIf.ld_grant); end
        sbIf.cache_ack = 1'b1;
        tick();
        sbIf.cache_ack = 1'b0;
        #1;
        checks++; if (sbIf.buf_count !== 3'd3 || sbIf.ld_grant !== 1'b1) begin
            errors++; $display("FAIL prio_after_pop got count=%0d grant=%b exp 3/1", sbIf.buf_count, sbIf.ld_grant); end
        tick();
        checks++; if (sbIf.cache_req !== 1'b0) begin errors++; $display("FAIL prio_no_req_below_full got %b exp 0", sbIf.cache_req); end
        sbIf.ld_valid = 1'b0;
        drainAll(40, drained);
        checks++; if (drained != 3 || sbIf.buf_empty !== 1'b1) begin
            errors++; $display("FAIL prio_drain_rest got drained=%0d empty=%b exp 3/1", drained, sbIf.buf_empty); end
        tick();
    endtask

    task automatic test_load_stall();
        pushStore(32'h2000_000A, 32'h00AB_0000, 4'b0100);
        sbIf.ld_valid = 1'b1;
        sbIf.ld_addr  = 32'h2000_0008;
        #1;
        checks++; if (sbIf.ld_stall !== 1'b1 || sbIf.ld_grant !== 1'b0) begin
            errors++; $display("FAIL stall_on_push got stall=%b grant=%b exp 1/0", sbIf.ld_stall, sbIf.ld_grant); end
        tick();
        sbIf.st_valid = 0;
        #1;
        checks++; if (sbIf.ld_stall !== 1'b1 || sbIf.ld_grant !== 1'b0 || sbIf.cache_req !== 1'b0) begin
            errors++; $display("FAIL stall_buffered got stall=%b grant=%b req=%b exp 1/0/0", sbIf.ld_stall, sbIf.ld_grant, sbIf.cache_req); end
        tick();
        checks++; if (sbIf.cache_req !== 1'b1 || sbIf.cache_addr !== 32'h2000_0008 || sbIf.cache_wen !== 4'b0100 || sbIf.ld_stall !== 1'b1) begin
            errors++; $display("FAIL stall_drain got req=%b addr=%h wen=%b stall=%b exp 1/20000008/0100/1", sbIf.cache_req, sbIf.cache_addr, sbIf.cache_wen, sbIf.ld_stall); end
        sbIf.cache_ack = 1'b1;
        #1;
        checks++; if (sbIf.ld_stall !== 1'b1) begin errors++; $display("FAIL stall_in_ack_cycle got %b exp 1", sbIf.ld_stall); end
        tick();
        sbIf.cache_ack = 1'b0;
        #1;
        checks++; if (sbIf.ld_stall !== 1'b0 || sbIf.ld_grant !== 1'b1 || sbIf.buf_empty !== 1'b1) begin
            errors++; $display("FAIL stall_released got stall=%b grant=%b empty=%b exp 0/1/1", sbIf.ld_stall, sbIf.ld_grant, sbIf.buf_empty); end
        sbIf.ld_valid = 1'b0;
        tick();
    endtask

    task automatic test_req_hold();
        pushStore(32'h0000_0400, 32'h0000_0055, 4'b0011);
        tick();
        sbIf.st_valid = 0;
        tick();
        sbIf.ld_addr = 32'h0000_0500;
        for (int i = 0; i < 5; i++) begin
            sbIf.ld_valid = (i % 2 == 0);
            #1;
            checks++; if (sbIf.cache_req !== 1'b1 || sbIf.cache_addr !== 32'h0000_0400 || sbIf.cache_wdata !== 32'h55 ||
                          sbIf.cache_wen !== 4'b0011 || sbIf.ld_grant !== 1'b0) begin
                errors++; $display("FAIL hold_cycle%0d got req=%b addr=%h data=%h wen=%b grant=%b exp 1/00000400/00000055/0011/0",
                                   i, sbIf.cache_req, sbIf.cache_addr, sbIf.cache_wdata, sbIf.cache_wen, sbIf.ld_grant); end
            tick();
        end
        sbIf.ld_valid  = 1'b0;
        sbIf.cache_ack = 1'b1;
        tick();
        sbIf.cache_ack = 1'b0;
        #1;
        checks++; if (sbIf.buf_empty !== 1'b1 || sbIf.cache_req !== 1'b0) begin
            errors++; $display("FAIL hold_done got empty=%b req=%b exp 1/0", sbIf.buf_empty, sbIf.cache_req); end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) begin
            pushStore(32'h0000_0600 + 32'(i * 4), 32'hC0 + 32'(i), 4'hF);
            tick();
        end
        sbIf.st_valid = 0;
        #1;
        checks++; if (sbIf.cache_req !== 1'b1 || sbIf.buf_count !== 3'd3) begin
            errors++; $display("FAIL rst_mid_setup got req=%b count=%0d exp 1/3", sbIf.cache_req, sbIf.buf_count); end
        sbIf.cache_ack = 1'b1;
        resetn = 1'b0;
        #1;
        checks++; if (sbIf.cache_req !== 1'b0 || sbIf.buf_count !== 3'd0 || sbIf.st_ready !== 1'b1 ||
                      sbIf.buf_empty !== 1'b1 || sbIf.cache_addr !== 32'h0) begin
            errors++; $display("FAIL rst_mid_immediate got req=%b count=%0d ready=%b empty=%b addr=%h exp 0/0/1/1/0",
                               sbIf.cache_req, sbIf.buf_count, sbIf.st_ready, sbIf.buf_empty, sbIf.cache_addr); end
        tick();
        resetn = 1'b1;
        sbIf.cache_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (sbIf.cache_req !== 1'b0 || sbIf.buf_count !== 3'd0) begin
                errors++; $display("FAIL rst_mid_no_drain cycle%0d got req=%b count=%0d exp 0/0", i, sbIf.cache_req, sbIf.buf_count); end
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_and_order();
        test_load_priority();
        test_load_stall();
        test_req_hold();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_store_buffer.md
Name: dcache_store_buffer

Overview:
- Small FIFO of committed stores placed between MEM-stage store commit and the single data-cache port.
- Accepts word address, data and byte-write-enable (the 4-bit byte-enable produced in EXE) per store.
- Drains entries to the cache when the port is idle, giving loads priority unless the buffer is full.
- Flags loads that hit a buffered word so the pipeline stalls instead of reading stale data.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, 2..16.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  core clock
- resetn  input  1  asynchronous active-low reset
- st_valid  input  1  committed store present this cycle
- st_addr  input  32  store byte address; bits [1:0] ignored
- st_data  input  32  store data, already lane-aligned
- st_wen  input  4  byte write enable
- st_ready  output  1  buffer can accept a store (not full)
- ld_valid  input  1  load wants the cache port this cycle
- ld_addr  input  32  load byte address
- ld_stall  output  1  load must stall: word match in buffer or on push
- ld_grant  output  1  cache port given to the load this cycle
- cache_req  output  1  drain request to the cache
- cache_addr  output  32  drain word address, {addr[31:2],2'b00}
- cache_wdata  output  32  drain data
- cache_wen  output  4  drain byte enable
- cache_ack  input  1  cache accepted the drain this cycle
- buf_empty  output  1  no valid entries
- buf_count  output  CNT_W  valid entry count

Behaviour:
- Reset (resetn low, asynchronous):
  - all entries invalid; head and tail pointers 0; FSM to IDLE.
  - cache_req=0, cache_addr/cache_wdata/cache_wen=0.
  - buf_empty=1, buf_count=0, st_ready=1.
  - Reset mid-drain abandons the entry; cache_ack arriving during reset is ignored.
- Push:
  - Occurs when st_valid && st_ready && st_wen!=0; entry written at tail and tail incremented (wraps at DEPTH).
  - st_valid with st_wen==0 is consumed without an entry.
  - st_ready = (count<DEPTH). It does not depend on a same-cycle pop.
  - st_valid while !st_ready is a protocol error; the store is dropped and the bench asserts this never happens.
- FSM, IDLE state:
  - Enter REQ when count>0 && (!ld_valid || count==DEPTH || ld_stall).
  - ld_grant = ld_valid && !ld_stall && !(count==DEPTH). It is combinational and 0 outside IDLE.
- FSM, REQ state:
  - cache_req=1, with addr/wdata/wen driven from the head entry.
  - These outputs must stay stable until cache_ack; a request is never retracted, even if a load arrives.
  - On cache_ack: pop head, head increments with wrap, return to IDLE.
  - Next drain earliest one cycle later, which gives a load a slot between drains.
  - ld_grant=0 while in REQ.
- Outputs are registered (cache_req, cache_*): the drain request starts 1 cycle after the IDLE decision. Latency from push into an empty buffer with no load to cache_req=1 is 2 cycles.
- Push and pop in the same cycle: count unchanged. A push when full in the same cycle as a pop is still refused, because st_ready reflects the registered count.
- ld_stall (combinational):
  - Asserted when ld_valid and either any valid entry, including the head under drain, has addr[31:2]==ld_addr[31:2], or a push is occurring with st_addr[31:2]==ld_addr[31:2].
  - Match ignores byte enables (conservative).
  - An entry stops matching in the cycle after its cache_ack.
- buf_count/buf_empty: registered, updated from push/pop each cycle; the count never exceeds DEPTH and never underflows.
- Pointers: CNT_W-bit count plus log2(DEPTH)-bit head/tail; order is strictly FIFO.

Test Plan:
- Reset then single SW push (addr 0x1000_0004, data 0xDEADBEEF, wen 1111), no loads, cache_ack one cycle after req -> cache_req high 2 cycles after push with cache_addr 0x1000_0004 and cache_wdata 0xDEADBEEF; buf_empty returns to 1 the cycle after ack.
- Push 4 stores (DEPTH=4) with cache_ack held 0 -> st_ready=0 at count 4; a 5th st_valid is not accepted; raising ack drains entries in push order 0,1,2,3.
- Continuous ld_valid to non-matching addresses with 2 buffered entries -> ld_grant=1 and no cache_req; fill to 4 entries -> ld_grant=0 and drain starts despite the loads.
- Load to 0x2000_0008 while a buffered SB to 0x2000_000A (wen 0100) is present -> ld_stall=1 until the cycle after that entry's cache_ack, then ld_grant=1.
- cache_req held with cache_ack low for 5 cycles while ld_valid toggles -> cache_addr/wdata/wen stable and cache_req never drops; ld_grant=0 throughout.
- Assert resetn=0 during REQ with 3 entries -> cache_req=0 immediately, buf_count=0, st_ready=1; no entries drain after release.
